// File: rtl/csr_pkg.sv
// csr_pkg: shared address map, FSM states and error-cause indices for apb_csr_ctrl_gen
package csr_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

    localparam int ERR_RD_WO = 0;
    localparam int ERR_WR_RO = 1;
    localparam int ERR_RANGE = 2;
    localparam int ERR_FULL  = 3;
    localparam int ERR_EMPTY = 4;
    localparam int ERR_OP    = 5;
    localparam int ERR_N     = 6;

    function automatic int last_data_addr(input int n);
        return n;
    endfunction

    function automatic int res_addr(input int n);
        return n + 1;
    endfunction

    function automatic int status_addr(input int n);
        return n + 2;
    endfunction

    function automatic int err_addr(input int n);
        return n + 3;
    endfunction

endpackage

// File: rtl/csr_err_decode.sv
// csr_err_decode: combinational error/cause decode of an APB setup; ERR register mapped when CSR_ERR_CODE_EN is defined
module csr_err_decode
    import csr_pkg::*;
#(
    parameter int NUM_DATA       = 2,
    parameter int NUM_OPS        = 2,
    parameter int OPERATION_SIZE = 2,
    parameter int ADDR_W         = $clog2(NUM_DATA + 4)
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      write,
    input  logic [OPERATION_SIZE-1:0] op,
    input  logic                      full_in,
    input  logic                      empty_out,
    output logic                      err,
    output logic [ERR_N-1:0]          cause
);

    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(last_data_addr(NUM_DATA));
    localparam logic [ADDR_W-1:0] A_RES  = ADDR_W'(res_addr(NUM_DATA));
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(status_addr(NUM_DATA));
    localparam logic [ADDR_W-1:0] A_ERR  = ADDR_W'(err_addr(NUM_DATA));

    logic             wr_reg, rd_reg, is_ctrl, is_err_reg;
    logic [ERR_N-1:0] raw;

    // Classify the address, raise every applicable cause, keep the lowest as the one-hot cause
    always_comb begin
        is_ctrl = addr == '0;
        wr_reg  = addr <= A_LAST;
`ifdef CSR_ERR_CODE_EN
        is_err_reg = addr == A_ERR;
`else
        is_err_reg = 1'b0;
`endif
        rd_reg          = addr == A_RES || addr == A_STAT || is_err_reg;
        raw             = '0;
        raw[ERR_RD_WO]  = !write && wr_reg;
        raw[ERR_WR_RO]  = write && rd_reg;
        raw[ERR_RANGE]  = !wr_reg && !rd_reg;
        raw[ERR_FULL]   = write && wr_reg && full_in;
        raw[ERR_EMPTY]  = !write && addr == A_RES && empty_out;
        raw[ERR_OP]     = write && is_ctrl && (op == '0 || 32'(op) > NUM_OPS);
        cause           = raw & (~raw + ERR_N'(1));
        err             = |raw;
    end

endmodule

// File: rtl/apb_csr_ctrl_gen.sv
// apb_csr_ctrl_gen: APB3 slave for the ALU CSR bank with register/FIFO strobes; CSR_ERR_CODE_EN adds the ERR cause register
module apb_csr_ctrl_gen
    import csr_pkg::*;
#(
    parameter int NUM_DATA       = 2,
    parameter int NUM_OPS        = 2,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int APB_BUS_SIZE   = 32,
    parameter int READ_WAIT      = 1,
    parameter int ADDR_W         = $clog2(NUM_DATA + 4)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         paddr,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_BUS_SIZE-1:0]   pwdata,
    input  logic                      full_in,
    input  logic                      empty_out,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
    output logic                      pready,
    output logic                      pslverr,
    output logic [APB_BUS_SIZE-1:0]   prdata,
    output logic [NUM_DATA:0]         reg_we,
    output logic                      fifo_in_wr_en,
    output logic                      fifo_out_rd_en
);

    localparam logic [ADDR_W-1:0] A_RES     = ADDR_W'(res_addr(NUM_DATA));
    localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(status_addr(NUM_DATA));
    localparam logic [2:0]        WAIT_INIT = 3'(READ_WAIT - 1);

    state_t            state, next_state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write, lat_err, lat_start;
    logic              dec_err, legal_rd, legal_wr, res_rd, done, setup;
    logic [ERR_N-1:0]  dec_cause;
    logic [APB_BUS_SIZE-1:0] rd_mux;
    logic              unused_bits;

    csr_err_decode #(
        .NUM_DATA       (NUM_DATA),
        .NUM_OPS        (NUM_OPS),
        .OPERATION_SIZE (OPERATION_SIZE),
        .ADDR_W         (ADDR_W)
    ) u_dec (
        .addr      (paddr),
        .write     (pwrite),
        .op        (pwdata[OPERATION_SIZE-1:0]),
        .full_in   (full_in),
        .empty_out (empty_out),
        .err       (dec_err),
        .cause     (dec_cause)
    );

`ifdef CSR_ERR_CODE_EN
    localparam logic [ADDR_W-1:0] A_ERR = ADDR_W'(err_addr(NUM_DATA));
    logic [ERR_N-1:0] lat_cause, err_q;

    assign unused_bits = ^{1'b0, pwdata[APB_BUS_SIZE-1:OPERATION_SIZE+1]};
    assign rd_mux = lat_addr == A_RES  ? APB_BUS_SIZE'(final_result) :
                    lat_addr == A_STAT ? APB_BUS_SIZE'(fifo_out_status) :
                    lat_addr == A_ERR  ? APB_BUS_SIZE'(err_q) : '0;

    // Sticky cause of the last errored transfer, cleared by a clean ERR read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cause <= '0;
            err_q     <= '0;
        end else begin
            if (setup)
                lat_cause <= dec_cause;
            if (done && lat_err)
                err_q <= lat_cause;
            else if (done && legal_rd && lat_addr == A_ERR)
                err_q <= '0;
        end
    end
`else
    assign unused_bits = ^{1'b0, pwdata[APB_BUS_SIZE-1:OPERATION_SIZE+1], dec_cause};
    assign rd_mux = lat_addr == A_RES  ? APB_BUS_SIZE'(final_result) :
                    lat_addr == A_STAT ? APB_BUS_SIZE'(fifo_out_status) : '0;
`endif

    // Transfer FSM next state plus the completion-cycle bus response and strobes
    always_comb begin
        setup          = state == ST_IDLE && psel && !penable;
        legal_rd       = !lat_write && !lat_err;
        legal_wr       = lat_write && !lat_err;
        res_rd         = legal_rd && lat_addr == A_RES;
        done           = psel && ((state == ST_ACCESS && !(res_rd && READ_WAIT > 0)) ||
                                  (state == ST_WAIT && cnt == '0));
        pready         = done;
        pslverr        = done && lat_err;
        prdata         = (done && legal_rd) ? rd_mux : '0;
        reg_we         = (done && legal_wr) ? (NUM_DATA + 1)'(1) << lat_addr : '0;
        fifo_out_rd_en = psel && state == ST_ACCESS && legal_rd &&
                         (lat_addr == A_RES || lat_addr == A_STAT);
        next_state     = state;
        case (state)
            ST_IDLE:   next_state = setup ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: next_state = (psel && !done) ? ST_WAIT : ST_IDLE;
            ST_WAIT:   next_state = (psel && !done) ? ST_WAIT : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Setup-phase latches, wait counter and the delayed FIFO_IN push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr      <= '0;
            lat_write     <= 1'b0;
            lat_err       <= 1'b0;
            lat_start     <= 1'b0;
            cnt           <= '0;
            fifo_in_wr_en <= 1'b0;
        end else begin
            if (setup) begin
                lat_addr  <= paddr;
                lat_write <= pwrite;
                lat_err   <= dec_err;
                lat_start <= pwdata[OPERATION_SIZE];
            end
            if (state == ST_ACCESS)
                cnt <= WAIT_INIT;
            else if (state == ST_WAIT && cnt != '0)
                cnt <= cnt - 3'd1;
            fifo_in_wr_en <= done && legal_wr && lat_addr == '0 && lat_start;
        end
    end

endmodule

// File: tb/tb_apb_csr_ctrl_gen.sv
// tb_apb_csr_ctrl_gen: randomized self-checking bench against a rule-level model of the CSR controller
module tb_apb_csr_ctrl_gen;

    localparam int ND = 2, NOPS = 2, RW = 3, AW = 3, FW = 25;
    localparam int A_RES = ND + 1, A_STAT = ND + 2, A_ERR = ND + 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic          full_in = 1'b0, empty_out = 1'b0;
    logic [FW-1:0] final_result = '0, fifo_out_status = '0;
    logic          pready, pslverr, fifo_in_wr_en, fifo_out_rd_en;
    logic [31:0]   prdata;
    logic [ND:0]   reg_we;

    int          errors = 0, checks = 0;
    logic [5:0]  err_model = '0;

    always #5 clk = ~clk;

    apb_csr_ctrl_gen #(
        .NUM_DATA(ND), .NUM_OPS(NOPS), .OPERATION_SIZE(2),
        .FIFO_OUT_WIDTH(FW), .APB_BUS_SIZE(32), .READ_WAIT(RW)
    ) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .full_in(full_in), .empty_out(empty_out),
        .final_result(final_result), .fifo_out_status(fifo_out_status),
        .pready(pready), .pslverr(pslverr), .prdata(prdata), .reg_we(reg_we),
        .fifo_in_wr_en(fifo_in_wr_en), .fifo_out_rd_en(fifo_out_rd_en)
    );

    function automatic logic [5:0] model_cause(input int a, input bit w, input int op,
                                               input bit full, input bit empty);
        bit has_err, writable, readable;
        logic [5:0] c;
        has_err = 0;
`ifdef CSR_ERR_CODE_EN
        has_err = 1;
`endif
        writable = a <= ND;
        readable = a == A_RES || a == A_STAT || (has_err && a == A_ERR);
        c    = '0;
        c[0] = !w && writable;
        c[1] = w && readable;
        c[2] = !writable && !readable;
        c[3] = w && writable && full;
        c[4] = !w && a == A_RES && empty;
        c[5] = w && a == 0 && (op == 0 || op > NOPS);
        return c;
    endfunction

    function automatic logic [5:0] lowest(input logic [5:0] c);
        for (int i = 0; i < 6; i++)
            if (c[i]) return 6'(1 << i);
        return '0;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One complete APB transfer, started at negedge+1, ends at negedge+1 of the cycle after completion
    task automatic xfer(input int a, input bit w, input logic [31:0] wd, input bit full, input bit empty,
                        input bit flip, input logic [FW-1:0] fr, input logic [FW-1:0] fs);
        logic [5:0]  c;
        bit          e, exp_pop, exp_push, fin, got_err, push_late, pop_first;
        int          exp_n, n, we_cyc, pop_cyc, push_early, stray;
        logic [31:0] exp_rd, got_rd;
        logic [ND:0] exp_we, we_or;
        c        = model_cause(a, w, int'(wd[1:0]), full, empty);
        e        = |c;
        exp_n    = (!e && !w && a == A_RES) ? RW + 1 : 1;
        exp_rd   = (e || w) ? 32'h0 : a == A_RES ? 32'(fr) : a == A_STAT ? 32'(fs) :
                   a == A_ERR ? 32'(err_model) : 32'h0;
        exp_we   = (!e && w) ? (ND + 1)'(1 << a) : '0;
        exp_pop  = !e && !w && (a == A_RES || a == A_STAT);
        exp_push = !e && w && a == 0 && wd[2];
        paddr = AW'(a); pwrite = w; pwdata = wd; full_in = full; empty_out = empty;
        final_result = fr; fifo_out_status = fs; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        if (flip) begin
            full_in = !full;
            empty_out = !empty;
        end
        n = 0; fin = 0; we_or = '0; we_cyc = 0; pop_cyc = 0; pop_first = 0;
        push_early = 0; stray = 0; got_err = 0; got_rd = '0;
        while (!fin && n < 20) begin
            #1;
            n++;
            we_or |= reg_we;
            if (reg_we != '0) we_cyc++;
            if (fifo_out_rd_en) begin
                pop_cyc++;
                if (n == 1) pop_first = 1;
            end
            if (fifo_in_wr_en) push_early++;
            if (pready) begin
                fin = 1; got_err = pslverr; got_rd = prdata;
            end else begin
                if (pslverr || prdata != '0) stray++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        #1;
        push_late = fifo_in_wr_en;
        if (reg_we != '0) we_cyc++;
        if (fifo_out_rd_en || pready) stray++;
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout a=%0d w=%0d: pready never seen within %0d cycles, want cycle %0d", a, w, n, exp_n);
        end
        checks++;
        if (n !== exp_n) begin
            errors++; $display("FAIL latency a=%0d w=%0d: pready cycle %0d, want %0d", a, w, n, exp_n);
        end
        checks++;
        if (got_err !== e) begin
            errors++; $display("FAIL pslverr a=%0d w=%0d: got %0b want %0b", a, w, got_err, e);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            errors++; $display("FAIL prdata a=%0d w=%0d: got %08h want %08h", a, w, got_rd, exp_rd);
        end
        checks++;
        if (we_or !== exp_we || we_cyc !== (exp_we != '0 ? 1 : 0)) begin
            errors++;
            $display("FAIL reg_we a=%0d w=%0d: got %b over %0d cycles, want %b once", a, w, we_or, we_cyc, exp_we);
        end
        checks++;
        if (pop_cyc !== int'(exp_pop) || pop_first !== exp_pop) begin
            errors++;
            $display("FAIL fifo_out_rd_en a=%0d: got %0d pulses (first cycle %0b), want %0d", a, pop_cyc, pop_first, exp_pop);
        end
        checks++;
        if (push_early !== 0 || push_late !== exp_push) begin
            errors++;
            $display("FAIL fifo_in_wr_en a=%0d: early %0d after %0b, want early 0 after %0b", a, push_early, push_late, exp_push);
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL stray_response a=%0d: %0d cycles with response outside completion, want 0", a, stray);
        end
        if (e) err_model = lowest(c);
        else if (!w && a == A_ERR) err_model = '0;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({pready, pslverr, prdata, reg_we, fifo_in_wr_en, fifo_out_rd_en} !== '0) begin
            errors++;
            $display("FAIL %s: pready=%b pslverr=%b prdata=%08h reg_we=%b push=%b pop=%b, want all 0",
                     name, pready, pslverr, prdata, reg_we, fifo_in_wr_en, fifo_out_rd_en);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        check_quiet("reset_held");
        rst = 1'b0;
        idle(2);
        check_quiet("after_reset");
        err_model = '0;
    endtask

    task automatic test_directed;
        xfer(1 + 1, 1, 32'h5, 0, 0, 0, '0, '0);
        xfer(0, 1, 32'h5, 0, 0, 0, '0, '0);
        xfer(0, 1, 32'h4, 0, 0, 0, '0, '0);
`ifdef CSR_ERR_CODE_EN
        xfer(A_ERR, 0, 32'h0, 0, 0, 0, '0, '0);
        xfer(A_ERR, 0, 32'h0, 0, 0, 0, '0, '0);
`endif
        idle(1);
        xfer(A_RES, 0, 32'h0, 0, 0, 0, 25'h1ABCDEF, 25'h0);
        idle(1);
        xfer(A_RES, 0, 32'h0, 0, 1, 0, 25'h1ABCDEF, 25'h0);
        xfer(A_STAT, 0, 32'h0, 0, 1, 0, 25'h0, 25'h155AA33);
        xfer(0, 1, 32'h6, 1, 0, 0, '0, '0);
        xfer(ND, 1, 32'h7, 0, 0, 1, '0, '0);
        xfer(A_RES, 0, 32'h0, 0, 0, 1, 25'h0F0F0F0, '0);
        xfer(7, 0, 32'h0, 0, 0, 0, '0, '0);
        xfer(A_ERR, 1, 32'h0, 0, 0, 0, '0, '0);
        xfer(0, 1, 32'h3, 0, 0, 0, '0, '0);
    endtask

    task automatic test_back_to_back;
        xfer(1, 1, 32'h15, 0, 0, 0, '0, '0);
        xfer(A_RES, 0, 32'h0, 0, 0, 0, 25'h0123456, '0);
        xfer(0, 1, 32'h6, 0, 0, 0, '0, '0);
        xfer(A_STAT, 0, 32'h0, 0, 0, 0, '0, 25'h1FFFFFF);
        xfer(1, 0, 32'h0, 0, 0, 0, '0, '0);
        idle(1);
    endtask

    task automatic test_abort;
        int bad;
        paddr = AW'(A_RES); pwrite = 1'b0; empty_out = 1'b0; final_result = 25'h1234567;
        psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (pready || pslverr || reg_we != '0 || fifo_out_rd_en || fifo_in_wr_en) bad++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL abort: %0d cycles with strobes after psel drop, want 0", bad);
        end
        xfer(2, 1, 32'h9, 0, 0, 0, '0, '0);
    endtask

    task automatic test_reset_mid;
        paddr = AW'(A_RES); pwrite = 1'b0; empty_out = 1'b0; final_result = 25'h0AAAAAA;
        psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("reset_mid_wait");
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
        check_quiet("reset_mid_next");
        rst = 1'b0;
        err_model = '0;
        idle(2);
        check_quiet("reset_mid_idle");
        xfer(1, 1, 32'h1, 0, 0, 0, '0, '0);
    endtask

    task automatic test_random;
        int a, gap;
        bit w;
        logic [31:0] wd;
        for (int k = 0; k < 120; k++) begin
            a   = $urandom_range(0, 7);
            w   = 1'($urandom_range(0, 1));
            wd  = {$urandom} & 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            gap = $urandom_range(0, 2);
            xfer(a, w, wd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), FW'($urandom), FW'($urandom));
            idle(gap);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
